// File: rtl/trng_fetch_ctrl_if.sv
// AXI4-Lite master-side bundle between trng_fetch_ctrl and the TRNG register slave.
// No logic and no added latency; it only groups the five AXI channels.
// Backpressure is the usual per-channel valid/ready handshake.
interface trng_fetch_ctrl_if;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    output araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
    input  araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/trng_fetch_ctrl.sv
// Enables the TRNG, polls STATUS, prefetches DATA words into a FIFO and deals them round-robin to consumers.
// Latency: push visible in fifo_level one cycle after DATA R handshake; req -> gnt is one cycle.
// Backpressure: DATA reads are only issued when the FIFO is not full; consumers just stall while it is empty.
module trng_fetch_ctrl #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_GAP   = 4
) (
  input  logic                        ACLK,
  input  logic                        ARESETN,
  input  logic                        en,
  trng_fetch_ctrl_if.master           m_axi,
  input  logic [NUM_REQ-1:0]          req,
  output logic [NUM_REQ-1:0]          gnt,
  output logic [31:0]                 rnd_data,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        busy,
  output logic                        err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [AW:0] FULL_LVL = (AW+1)'(FIFO_DEPTH);
  localparam logic [7:0]  GAP_LAST = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);
  localparam logic [1:0]  OKAY     = 2'b00;

  typedef enum logic [2:0] {
    S_IDLE, S_CFG, S_CFG_B, S_POLL_AR, S_POLL_R, S_GAP, S_DATA_AR, S_DATA_R
  } state_t;

  state_t      state_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [31:0] awaddr_q, wdata_q, araddr_q;
  logic        busy_q, err_q;
  logic [7:0]  gap_q;

  logic [31:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [AW:0]        count_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [31:0]        rnd_data_q;
  logic [IW-1:0]      last_gnt_q;

  logic          fifo_full, fifo_empty, push, pop, win_vld;
  logic [IW-1:0] win_idx, idx;

  assign fifo_full  = (count_q == FULL_LVL);
  assign fifo_empty = (count_q == '0);
  // Only a clean DATA response is stored; an errored word is dropped.
  assign push = (state_q == S_DATA_R) && rready_q && m_axi.rvalid && (m_axi.rresp == OKAY);
  assign pop  = win_vld && !fifo_empty;

  // Control FSM: one AXI transaction at a time, en honoured only between transactions.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q   <= S_IDLE;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      araddr_q  <= '0;
      busy_q    <= 1'b0;
      err_q     <= 1'b0;
      gap_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (en) begin
          state_q   <= S_CFG;
          busy_q    <= 1'b1;
          awvalid_q <= 1'b1;
          wvalid_q  <= 1'b1;
          awaddr_q  <= BASE_ADDR;
          wdata_q   <= 32'h1;
        end
        S_CFG: begin
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          if ((!awvalid_q || m_axi.awready) && (!wvalid_q || m_axi.wready)) begin
            state_q  <= S_CFG_B;
            bready_q <= 1'b1;
          end
        end
        S_CFG_B: if (m_axi.bvalid) begin
          bready_q <= 1'b0;
          if (m_axi.bresp != OKAY) err_q <= 1'b1;
          if (!en) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_POLL_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_ADDR + 32'h4;
          end
        end
        S_POLL_AR: if (m_axi.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_POLL_R;
        end
        S_POLL_R: if (m_axi.rvalid) begin
          rready_q <= 1'b0;
          if (m_axi.rresp != OKAY) err_q <= 1'b1;
          if (!en) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else if ((m_axi.rresp == OKAY) && m_axi.rdata[0] && !fifo_full) begin
            state_q   <= S_DATA_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_ADDR + 32'h8;
          end else if (POLL_GAP == 0) begin
            state_q   <= S_POLL_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_ADDR + 32'h4;
          end else begin
            state_q <= S_GAP;
            gap_q   <= '0;
          end
        end
        S_GAP: begin
          if (gap_q == GAP_LAST) begin
            if (!en) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q   <= S_POLL_AR;
              arvalid_q <= 1'b1;
              araddr_q  <= BASE_ADDR + 32'h4;
            end
          end else begin
            gap_q <= gap_q + 8'd1;
          end
        end
        S_DATA_AR: if (m_axi.arready) begin
          arvalid_q <= 1'b0;
          rready_q  <= 1'b1;
          state_q   <= S_DATA_R;
        end
        S_DATA_R: if (m_axi.rvalid) begin
          rready_q <= 1'b0;
          if (m_axi.rresp != OKAY) err_q <= 1'b1;
          if (!en) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end else begin
            state_q   <= S_POLL_AR;
            arvalid_q <= 1'b1;
            araddr_q  <= BASE_ADDR + 32'h4;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Round-robin pick: scan upward from the slot after the last winner, wrapping at NUM_REQ.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    idx     = (last_gnt_q == IW'(NUM_REQ - 1)) ? '0 : last_gnt_q + 1'b1;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_vld && req[idx]) begin
        win_vld = 1'b1;
        win_idx = idx;
      end
      idx = (idx == IW'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
    end
  end

  // FIFO storage; contents need no reset since the pointers define what is valid.
  always_ff @(posedge ACLK) begin
    if (push) mem[wr_ptr_q] <= m_axi.rdata;
  end

  // FIFO pointers, occupancy and registered grant; the head word pops on the edge that raises gnt.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      gnt_q      <= '0;
      rnd_data_q <= '0;
      last_gnt_q <= IW'(NUM_REQ - 1);
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      gnt_q <= pop ? (NUM_REQ'(1) << win_idx) : '0;
      if (pop) begin
        rnd_data_q <= mem[rd_ptr_q];
        last_gnt_q <= win_idx;
      end
    end
  end

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = araddr_q;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  assign gnt        = gnt_q;
  assign rnd_data   = rnd_data_q;
  assign fifo_level = count_q;
  assign busy       = busy_q;
  assign err        = err_q;
endmodule
